// File: rtl/bht_resolve_queue.sv
// In-order queue of fetch-time branch predictions. Each entry retires when execute resolves it,
// trains the BHT and flushes on a mispredict. Optional statistics counters: BHT_RESOLVE_STATS_EN.
module bht_resolve_queue #(
    parameter int DEPTH       = 8,
    parameter int PC_W        = 9,
    parameter int CNT_W       = 16,
    parameter int RECOVER_CYC = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_underflow,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_RECOVER
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     rec_q, rec_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic              upd_valid_q, upd_valid_d;
    logic [PC_W-1:0]   upd_pc_q, upd_pc_d;
    logic              upd_taken_q, upd_taken_d;
    logic              mispredict_q, mispredict_d;
    logic              err_q, err_d;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic              pred_mem [DEPTH];

    logic [PW-1:0]     occ;
    logic [AW-1:0]     head_idx, tail_idx;
    logic              empty, full, pop, push, miss;

    assign occ      = tail_q - head_q;
    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    assign empty    = (occ == '0);
    assign full     = (occ == FULL_OCC);
    assign pop      = res_valid && !empty;
    assign miss     = pop && (pred_mem[head_idx] != res_taken);
    // A full queue still accepts a push when the head retires in the same cycle.
    assign pred_ready = (state_q == ST_RUN) && (!full || pop);
    assign push       = pred_valid && pred_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        state_d = state_q;
        rec_d   = rec_q;
        case (state_q)
            ST_RUN: begin
                if (miss) begin
                    // Everything younger than the mispredicted branch is wrong-path.
                    head_d  = '0;
                    tail_d  = '0;
                    state_d = ST_RECOVER;
                    rec_d   = RW'(RECOVER_CYC - 1);
                end else begin
                    if (pop)  head_d = head_q + PW'(1);
                    if (push) tail_d = tail_q + PW'(1);
                end
            end
            ST_RECOVER: begin
                if (rec_q == '0) state_d = ST_RUN;
                else             rec_d   = rec_q - RW'(1);
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        upd_valid_d  = pop;
        upd_pc_d     = pop ? pc_mem[head_idx] : upd_pc_q;
        upd_taken_d  = pop ? res_taken : upd_taken_q;
        mispredict_d = miss;
        err_d        = err_q | (res_valid && empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            rec_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rec_q        <= rec_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            upd_valid_q  <= upd_valid_d;
            upd_pc_q     <= upd_pc_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
            err_q        <= err_d;
        end
    end

    // Entry storage needs no reset: validity is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !miss) begin
            pc_mem[tail_idx]   <= pred_pc;
            pred_mem[tail_idx] <= pred_taken;
        end
    end

    assign upd_valid     = upd_valid_q;
    assign upd_pc        = upd_pc_q;
    assign upd_taken     = upd_taken_q;
    assign mispredict    = mispredict_q;
    assign occupancy     = occ;
    assign err_underflow = err_q;

`ifdef BHT_RESOLVE_STATS_EN
    logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (pop && (bcnt_q != '1))  bcnt_d = bcnt_q + CNT_W'(1);
        if (miss && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign branch_cnt = bcnt_q;
    assign miss_cnt   = mcnt_q;
`else
    assign branch_cnt = '0;
    assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_bht_resolve_queue.sv
// Scoreboard bench for bht_resolve_queue: queue-based reference model, random and directed stimulus.
module tb_bht_resolve_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 9;
    localparam int CNT_W = 4;
    localparam int RC    = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic [PC_W-1:0] pred_pc = '0;
    logic pred_ready, upd_valid, upd_taken, mispredict, err_underflow;
    logic [PC_W-1:0] upd_pc;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] branch_cnt, miss_cnt;

    bht_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W), .RECOVER_CYC(RC)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .mispredict(mispredict),
        .occupancy(occupancy), .err_underflow(err_underflow),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [PC_W-1:0] pc; logic pred; } ent_t;
    typedef struct packed { logic [PC_W-1:0] pc; logic taken; logic miss; } upd_t;

    ent_t mq[$];
    upd_t sb[$];
    int   recov_left = 0;
    int   m_b = 0, m_m = 0, exp_occ = 0;
    bit   m_err = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0, failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef BHT_RESOLVE_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        recov_left = 0;
        m_b = 0;
        m_m = 0;
        m_err = 1'b0;
        exp_occ = 0;
    endtask

    // One cycle: drive inputs, check the combinational ready, advance the model to post-edge state.
    task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic pt,
                        input logic rv, input logic rt);
        bit   pop, ready, miss;
        ent_t h;
        @(negedge clk);
        pred_valid = pv; pred_pc = pc; pred_taken = pt;
        res_valid  = rv; res_taken = rt;
        #1;
        pop   = rv && (mq.size() > 0);
        ready = (recov_left == 0) && ((mq.size() < DEPTH) || pop);
        check("pred_ready", pred_ready, ready);
        if (recov_left > 0) recov_left--;
        if (rv && mq.size() == 0) m_err = 1'b1;
        miss = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            miss = (h.pred != rt);
            m_b = sat_inc(m_b);
            if (miss) m_m = sat_inc(m_m);
            sb.push_back('{pc: h.pc, taken: rt, miss: miss});
        end
        if (miss) begin
            mq.delete();
            recov_left = RC;
        end else if (pv && ready) begin
            mq.push_back('{pc: pc, pred: pt});
        end
        exp_occ = mq.size();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        upd_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (upd_valid) begin
                    if (sb.size() == 0) begin
                        check("upd_valid_spurious", upd_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("upd_pc", upd_pc, e.pc);
                        check("upd_taken", upd_taken, e.taken);
                        check("mispredict", mispredict, e.miss);
                    end
                end else begin
                    check("mispredict_idle", mispredict, 0);
                    check("upd_missing", sb.size(), 0);
                end
                check("occupancy", occupancy, exp_occ);
                check("err_underflow", err_underflow, m_err);
                check("branch_cnt", branch_cnt, exp_cnt(m_b));
                check("miss_cnt", miss_cnt, exp_cnt(m_m));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_pred_ready"}, pred_ready, 1);
        check({tag, "_upd_valid"}, upd_valid, 0);
        check({tag, "_upd_pc"}, upd_pc, 0);
        check({tag, "_upd_taken"}, upd_taken, 0);
        check({tag, "_mispredict"}, mispredict, 0);
        check({tag, "_err"}, err_underflow, 0);
        check({tag, "_branch_cnt"}, branch_cnt, 0);
        check({tag, "_miss_cnt"}, miss_cnt, 0);
    endtask

    initial begin : stim
        logic rt;
        logic [PC_W-1:0] base;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Single matching resolve
        step(1'b1, 9'h012, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("first_branch_cnt", branch_cnt, exp_cnt(1));

        // Fill, then push and matching pop together while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 9'h100 + PC_W'(i), 1'(i & 1), 1'b0, 1'b0);
        idle(1);
        check("full_occupancy", occupancy, DEPTH);
        step(1'b1, 9'h0AA, 1'b1, 1'b1, 1'b0);
        idle(1);
        check("full_push_pop_occ", occupancy, DEPTH);
        for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b1, 1'(i & 1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Mispredict with simultaneous push, then recovery window
        step(1'b1, 9'h031, 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h032, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9'h033, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9'h034, 1'b1, 1'b1, 1'b1);
        step(1'b1, 9'h035, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9'h036, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9'h037, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Underflow is sticky
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("underflow_sticky", err_underflow, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (mq.size() > 0) rt = ($urandom_range(0, 7) == 0) ? ~mq[0].pred : mq[0].pred;
            else               rt = 1'($urandom);
            step(1'($urandom_range(0, 9) < 6), PC_W'($urandom), 1'($urandom),
                 1'($urandom_range(0, 9) < 4), rt);
        end
        idle(4);

        // Asynchronous reset mid-cycle with entries queued
        for (int i = 0; i < 5; i++) step(1'b1, 9'h0C0 + PC_W'(i), 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        pred_valid = 1'b0; res_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        step(1'b1, 9'h155, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Drive both counters into saturation
        base = 9'h1E0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, base + PC_W'(i), 1'b0, 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b1, 1'b1);
            idle(RC);
        end
        idle(1);
        check("branch_cnt_sat", branch_cnt, exp_cnt(CMAX));
        check("miss_cnt_sat", miss_cnt, exp_cnt(CMAX));
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
